// File: rtl/axilite4_rr_read_arbiter.sv
// axilite4_rr_read_arbiter: four AXI4-Lite read masters share one slave under round-robin arbitration.
// Latency: one registered arbitration cycle in IDLE, then ADDR and DATA pass through combinationally.
// Backpressure: s_arready / m_rready stall ADDR / DATA indefinitely, or until the optional watchdog fires.
//
// Ports: clk/rst (async active-high); m_* = packed 4-master AR/R channels (master i at slice i);
//        s_* = single slave AR/R channel; grant = current owner, busy = not idle,
//        timeout_err = one-cycle pulse when the DATA watchdog expires.
// Optional feature: define AXIL_ARB_TIMEOUT_EN to build the DATA-phase watchdog and ERR state;
//        TIMEOUT_CYC sets the number of stalled DATA cycles tolerated.
module axilite4_rr_read_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] m_araddr,
    input  logic [3:0]   m_arvalid,
    output logic [3:0]   m_arready,
    output logic [127:0] m_rdata,
    output logic [3:0]   m_rvalid,
    input  logic [3:0]   m_rready,
    output logic [31:0]  s_araddr,
    output logic         s_arvalid,
    input  logic         s_arready,
    input  logic [127:0] s_rdata,
    input  logic         s_rvalid,
    output logic         s_rready,
    output logic [1:0]   grant,
    output logic         busy,
    output logic         timeout_err
);

`ifdef AXIL_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
`endif

    state_t     state, state_nxt;
    logic [1:0] grant_nxt;
    logic [1:0] last_grant, last_grant_nxt;
    logic [1:0] rr_pick;
    logic       rr_found;
    logic       r_hs;

    assign busy = (state != IDLE);
    assign r_hs = s_rvalid && m_rready[grant];

    // Scan last_grant+1 .. last_grant+4 so the previous owner is considered last.
    always_comb begin
        rr_pick  = last_grant;
        rr_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_found && m_arvalid[last_grant + 2'(k)]) begin
                rr_pick  = last_grant + 2'(k);
                rr_found = 1'b1;
            end
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int CW = 16;
    logic [CW-1:0] to_cnt;
    logic          to_hit;

    // Fires on the stalled DATA cycle that brings the count up to TIMEOUT_CYC.
    assign to_hit = (state == DATA) && !r_hs && (to_cnt == CW'(TIMEOUT_CYC - 1));

    // Counter sits at zero outside DATA, so it is clear on every DATA entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= to_hit;
            if (state != DATA) begin
                to_cnt <= '0;
            end else if (!r_hs) begin
                to_cnt <= to_cnt + CW'(1);
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 2'd0;
            last_grant <= 2'd3;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        m_arready      = '0;
        m_rdata        = '0;
        m_rvalid       = '0;
        s_araddr       = '0;
        s_arvalid      = 1'b0;
        s_rready       = 1'b0;
        case (state)
            IDLE: begin
                if (|m_arvalid) begin
                    grant_nxt = rr_pick;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                s_araddr         = m_araddr[{grant, 5'd0} +: 32];
                s_arvalid        = m_arvalid[grant];
                m_arready[grant] = s_arready;
                if (m_arvalid[grant] && s_arready) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                m_rdata         = s_rdata;
                m_rvalid[grant] = s_rvalid;
                s_rready        = m_rready[grant];
                if (r_hs) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
`ifdef AXIL_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    state_nxt = ERR;
                end
`endif
            end
`ifdef AXIL_ARB_TIMEOUT_EN
            // Slave never answered: return an all-ones beat to the owner without touching the slave.
            ERR: begin
                m_rdata         = '1;
                m_rvalid[grant] = 1'b1;
                if (m_rready[grant]) begin
                    state_nxt      = IDLE;
                    last_grant_nxt = grant;
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axilite4_rr_read_arbiter.sv
`timescale 1ns/1ps
module tb_axilite4_rr_read_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [127:0] m_araddr;
    logic [3:0]   m_arvalid;
    logic [3:0]   m_arready;
    logic [127:0] m_rdata;
    logic [3:0]   m_rvalid;
    logic [3:0]   m_rready;
    logic [31:0]  s_araddr;
    logic         s_arvalid;
    logic         s_arready;
    logic [127:0] s_rdata;
    logic         s_rvalid;
    logic         s_rready;
    logic [1:0]   grant;
    logic         busy;
    logic         timeout_err;

    int checks   = 0;
    int failures = 0;

    axilite4_rr_read_arbiter #(.TIMEOUT_CYC(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_araddr   (m_araddr),
        .m_arvalid  (m_arvalid),
        .m_arready  (m_arready),
        .m_rdata    (m_rdata),
        .m_rvalid   (m_rvalid),
        .m_rready   (m_rready),
        .s_araddr   (s_araddr),
        .s_arvalid  (s_arvalid),
        .s_arready  (s_arready),
        .s_rdata    (s_rdata),
        .s_rvalid   (s_rvalid),
        .s_rready   (s_rready),
        .grant      (grant),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the active edge; outputs are read 1ns later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one complete transaction for whatever m_arvalid the caller set (in IDLE).
    // ar_wait: ADDR cycles with s_arready low; rv_lat / rr_lat: DATA cycles before s_rvalid / m_rready.
    task automatic run_txn(input int ar_wait, input int rv_lat, input int rr_lat,
                           input logic [127:0] data,
                           output logic [1:0] g, output logic [31:0] addr,
                           output logic [127:0] rd, output logic [3:0] rv,
                           output int busy_cyc, output int ar_hs, output int r_hs, output int cyc);
        time t0;
        int  dmax;
        t0 = $time;
        busy_cyc = 0; ar_hs = 0; r_hs = 0; rd = '0; rv = '0; g = 2'd0; addr = '0;
        s_arready = (ar_wait == 0);
        #1;
        busy_cyc += int'(busy);
        tick;
        for (int i = 0; i <= ar_wait; i++) begin
            s_arready = (i == ar_wait);
            #1;
            if (i == 0) begin
                g    = grant;
                addr = s_araddr;
            end
            busy_cyc += int'(busy);
            ar_hs    += int'(s_arvalid & s_arready);
            tick;
        end
        s_arready = 1'b0;
        dmax = (rv_lat > rr_lat) ? rv_lat : rr_lat;
        for (int d = 0; d <= dmax; d++) begin
            s_rvalid = (d >= rv_lat);
            s_rdata  = s_rvalid ? data : '0;
            m_rready = (d >= rr_lat) ? 4'hF : 4'h0;
            #1;
            busy_cyc += int'(busy);
            if (s_rvalid && s_rready) begin
                r_hs++;
                rd = m_rdata;
                rv = m_rvalid;
            end
            tick;
        end
        s_rvalid = 1'b0;
        s_rdata  = '0;
        m_rready = 4'h0;
        #1;
        busy_cyc += int'(busy);
        cyc = int'(($time - t0) / 10);
    endtask

    task automatic pulse_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        checks++;
        if (grant !== 2'd0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: grant=%0d busy=%b timeout_err=%b, required 0 0 0", grant, busy, timeout_err);
        end
        checks++;
        if ({m_arready, m_rvalid, s_arvalid, s_rready} !== 10'd0) begin
            failures++;
            $display("FAIL reset_handshakes: got %b, required all zero", {m_arready, m_rvalid, s_arvalid, s_rready});
        end
        checks++;
        if (m_rdata !== 128'd0 || s_araddr !== 32'd0) begin
            failures++;
            $display("FAIL reset_data: m_rdata=%h s_araddr=%h, required 0", m_rdata, s_araddr);
        end
        tick;
        tick;
        rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || grant !== 2'd0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b grant=%0d, required 0 0", busy, grant);
        end
    endtask

    task automatic test_single;
        logic [1:0] g; logic [31:0] a; logic [127:0] rd; logic [3:0] rv;
        int bc, ah, rh, cy;
        m_arvalid = 4'b0001;
        run_txn(0, 2, 0, 128'hA5, g, a, rd, rv, bc, ah, rh, cy);
        m_arvalid = 4'b0000;
        checks++;
        if (g !== 2'd0) begin failures++; $display("FAIL single_grant: got %0d required 0", g); end
        checks++;
        if (a !== 32'h1000) begin failures++; $display("FAIL single_addr: got %h required 00001000", a); end
        checks++;
        if (rh !== 1 || rd !== 128'hA5 || rv !== 4'b0001) begin
            failures++;
            $display("FAIL single_rdata: hs=%0d rdata=%h rvalid=%b, required 1 a5 0001", rh, rd, rv);
        end
        checks++;
        if (bc !== 4) begin failures++; $display("FAIL single_busy_cycles: got %0d required 4", bc); end
    endtask

    task automatic test_all_contend;
        logic [1:0] g; logic [31:0] a; logic [127:0] rd; logic [3:0] rv;
        int bc, ah, rh, cy;
        logic [1:0] exp_g;
        pulse_reset();
        m_arvalid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            exp_g = 2'(i);
            run_txn(0, 0, 0, 128'(i + 16), g, a, rd, rv, bc, ah, rh, cy);
            checks++;
            if (g !== exp_g) begin
                failures++;
                $display("FAIL contend_grant[%0d]: got %0d required %0d", i, g, exp_g);
            end
            checks++;
            if (a !== 32'h1000 * (32'(exp_g) + 32'd1) || rd !== 128'(i + 16)) begin
                failures++;
                $display("FAIL contend_data[%0d]: addr=%h rdata=%h", i, a, rd);
            end
            checks++;
            if (cy !== 3) begin
                failures++;
                $display("FAIL back_to_back_cycles[%0d]: got %0d required 3", i, cy);
            end
        end
        m_arvalid = 4'b0000;
    endtask

    task automatic test_late_requester;
        logic held_ok;
        m_arvalid = 4'b0100;
        s_arready = 1'b1;
        tick;
        #1;
        checks++;
        if (grant !== 2'd2) begin failures++; $display("FAIL late_initial_grant: got %0d required 2", grant); end
        tick;
        m_arvalid = 4'b0101;
        s_arready = 1'b0;
        m_rready  = 4'hF;
        held_ok   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (grant !== 2'd2 || busy !== 1'b1 || m_arready !== 4'b0000) held_ok = 1'b0;
            tick;
        end
        checks++;
        if (held_ok !== 1'b1) begin failures++; $display("FAIL late_hold: grant=%0d busy=%b, required 2 1", grant, busy); end
        s_rvalid = 1'b1;
        s_rdata  = 128'h77;
        #1;
        checks++;
        if (grant !== 2'd2 || m_rvalid !== 4'b0100) begin
            failures++;
            $display("FAIL late_handshake: grant=%0d m_rvalid=%b, required 2 0100", grant, m_rvalid);
        end
        tick;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL late_idle: busy=%b required 0", busy); end
        tick;
        #1;
        checks++;
        if (grant !== 2'd0) begin failures++; $display("FAIL late_next_grant: got %0d required 0", grant); end
        s_arready = 1'b1;
        tick;
        m_arvalid = 4'b0000;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        tick;
        s_rvalid = 1'b0;
        m_rready = 4'h0;
    endtask

    task automatic test_backpressure;
        logic [1:0] g; logic [31:0] a; logic [127:0] rd; logic [3:0] rv;
        int bc, ah, rh, cy;
        m_arvalid = 4'b0010;
        run_txn(5, 0, 3, 128'hBEEF, g, a, rd, rv, bc, ah, rh, cy);
        m_arvalid = 4'b0000;
        checks++;
        if (g !== 2'd1 || a !== 32'h2000) begin
            failures++;
            $display("FAIL bp_grant_addr: grant=%0d addr=%h, required 1 00002000", g, a);
        end
        checks++;
        if (ah !== 1 || rh !== 1) begin
            failures++;
            $display("FAIL bp_single_read: ar_hs=%0d r_hs=%0d, required 1 1", ah, rh);
        end
        checks++;
        if (bc !== 10 || cy !== 11) begin
            failures++;
            $display("FAIL bp_hold_cycles: busy=%0d total=%0d, required 10 11", bc, cy);
        end
        checks++;
        if (rd !== 128'hBEEF || rv !== 4'b0010) begin
            failures++;
            $display("FAIL bp_rdata: rdata=%h rvalid=%b, required beef 0010", rd, rv);
        end
    endtask

    task automatic test_priority;
        logic [1:0] g; logic [31:0] a; logic [127:0] rd; logic [3:0] rv;
        int bc, ah, rh, cy;
        m_arvalid = 4'b1001;
        run_txn(0, 0, 0, 128'h1, g, a, rd, rv, bc, ah, rh, cy);
        checks++;
        if (g !== 2'd3) begin failures++; $display("FAIL priority_after1: got %0d required 3", g); end
        run_txn(0, 0, 0, 128'h2, g, a, rd, rv, bc, ah, rh, cy);
        m_arvalid = 4'b0000;
        checks++;
        if (g !== 2'd0) begin failures++; $display("FAIL priority_after3: got %0d required 0", g); end
    endtask

`ifdef AXIL_ARB_TIMEOUT_EN
    task automatic test_timeout;
        int first_to; int pulses;
        logic [3:0] rv10; logic [127:0] rd10; logic rr10;
        first_to = -1; pulses = 0; rv10 = '0; rd10 = '0; rr10 = 1'b1;
        m_arvalid = 4'b0100;
        s_arready = 1'b1;
        m_rready  = 4'h0;
        tick;
        tick;
        m_arvalid = 4'b0000;
        s_arready = 1'b0;
        for (int d = 0; d < 15; d++) begin
            #1;
            if (timeout_err === 1'b1) begin
                pulses++;
                if (first_to < 0) first_to = d;
            end
            if (d == 10) begin
                rv10 = m_rvalid; rd10 = m_rdata; rr10 = s_rready;
            end
            tick;
        end
        checks++;
        if (first_to !== 10 || pulses !== 1) begin
            failures++;
            $display("FAIL timeout_pulse: first=%0d pulses=%0d, required 10 1", first_to, pulses);
        end
        checks++;
        if (rv10 !== 4'b0100 || rd10 !== {128{1'b1}} || rr10 !== 1'b0) begin
            failures++;
            $display("FAIL timeout_err_beat: rvalid=%b rdata=%h s_rready=%b", rv10, rd10, rr10);
        end
        m_rready = 4'b0100;
        tick;
        m_rready = 4'h0;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL timeout_return_idle: busy=%b required 0", busy); end
    endtask
`else
    task automatic test_no_timeout;
        logic ok;
        ok = 1'b1;
        m_arvalid = 4'b0100;
        s_arready = 1'b1;
        m_rready  = 4'h0;
        tick;
        tick;
        m_arvalid = 4'b0000;
        s_arready = 1'b0;
        for (int d = 0; d < 20; d++) begin
            #1;
            if (timeout_err !== 1'b0 || busy !== 1'b1 || m_rvalid !== 4'b0000) ok = 1'b0;
            tick;
        end
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL no_timeout_wait: timeout_err=%b busy=%b m_rvalid=%b", timeout_err, busy, m_rvalid);
        end
        s_rvalid = 1'b1;
        s_rdata  = 128'h33;
        m_rready = 4'hF;
        #1;
        checks++;
        if (m_rvalid !== 4'b0100 || m_rdata !== 128'h33 || grant !== 2'd2) begin
            failures++;
            $display("FAIL no_timeout_complete: m_rvalid=%b m_rdata=%h grant=%0d", m_rvalid, m_rdata, grant);
        end
        tick;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        m_rready = 4'h0;
    endtask
`endif

    task automatic test_reset_mid;
        m_arvalid = 4'b1000;
        s_arready = 1'b1;
        tick;
        tick;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 128'h55;
        m_rready  = 4'h0;
        #1;
        checks++;
        if (m_rvalid !== 4'b1000 || m_rdata !== 128'h55) begin
            failures++;
            $display("FAIL rstmid_pre: m_rvalid=%b m_rdata=%h, required 1000 55", m_rvalid, m_rdata);
        end
        m_rready = 4'hF;
        rst      = 1'b1;
        #1;
        checks++;
        if ({m_arready, m_rvalid, s_arvalid, s_rready, busy, timeout_err} !== 12'd0 || grant !== 2'd0) begin
            failures++;
            $display("FAIL rstmid_ctrl: got %b grant=%0d, required all zero",
                     {m_arready, m_rvalid, s_arvalid, s_rready, busy, timeout_err}, grant);
        end
        checks++;
        if (m_rdata !== 128'd0 || s_araddr !== 32'd0) begin
            failures++;
            $display("FAIL rstmid_data: m_rdata=%h s_araddr=%h, required 0", m_rdata, s_araddr);
        end
        m_arvalid = 4'b0000;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        m_rready  = 4'h0;
        tick;
        rst       = 1'b0;
        m_arvalid = 4'b0011;
        tick;
        #1;
        checks++;
        if (grant !== 2'd0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_next_grant: grant=%0d busy=%b, required 0 1", grant, busy);
        end
        s_arready = 1'b1;
        tick;
        m_arvalid = 4'b0000;
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        m_rready  = 4'hF;
        tick;
        s_rvalid = 1'b0;
        m_rready = 4'h0;
    endtask

    initial begin
        m_araddr  = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
        m_arvalid = 4'b0000;
        m_rready  = 4'h0;
        s_arready = 1'b0;
        s_rdata   = '0;
        s_rvalid  = 1'b0;
        test_reset();
        test_single();
        test_all_contend();
        test_late_requester();
        test_backpressure();
        test_priority();
`ifdef AXIL_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
